// File: rtl/ysyx_25040109_ifu.sv
// ysyx_25040109_ifu: instruction fetch unit of the multi-cycle core.
// Issues one single-beat AXI4 read per fetch at the current PC and hands the
// word and its PC to decode over valid/ready. The next PC comes from
// writeback, and flush from trap/branch logic redirects the PC.
// Optional feature macro: IFU_PERF_EN adds the perf_fetch_cnt and
// perf_wait_cyc counter outputs.
module ysyx_25040109_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [3:0]  AXI_ID   = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_arvalid,
  input  logic        imem_arready,
  output logic [31:0] imem_araddr,
  output logic [3:0]  imem_arid,
  output logic [7:0]  imem_arlen,
  output logic [2:0]  imem_arsize,
  output logic [1:0]  imem_arburst,
  input  logic        imem_rvalid,
  output logic        imem_rready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  input  logic [3:0]  imem_rid,
  input  logic        imem_rlast,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cyc
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_OUT, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ar_addr_q;
  logic        discard_q;
  logic        ar_misaligned;
  logic        unused_rsig;

  // Single beat only: the R id and last flag carry no information here.
  assign unused_rsig   = ^{imem_rid, imem_rlast};

  assign ar_misaligned = (ar_addr_q[1:0] != 2'b00);

  assign imem_araddr  = ar_addr_q;
  assign imem_arid    = AXI_ID;
  assign imem_arlen   = 8'd0;
  assign imem_arsize  = 3'b010;
  assign imem_arburst = 2'b01;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always restarts a fetch, except that an AR that is
  // already presented (or a pending R beat) must complete first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_AR;
      S_AR: begin
        if (ar_misaligned)     state_d = flush ? S_AR : S_OUT;
        else if (imem_arready) state_d = S_R;
      end
      S_R: if (imem_rvalid) state_d = (discard_q || flush) ? S_AR : S_OUT;
      S_OUT: begin
        if (flush)           state_d = S_AR;
        else if (inst_ready) state_d = S_WAIT;
      end
      S_WAIT: if (flush || npc_valid) state_d = S_AR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    imem_arvalid = (state_q == S_AR) && !ar_misaligned;
    imem_rready  = (state_q == S_R);
    inst_valid   = (state_q == S_OUT);
  end

  // Next PC: flush has priority; npc is only honoured while waiting for it
  always_comb begin
    pc_d = pc_q;
    if (flush)                             pc_d = flush_pc;
    else if (state_q == S_WAIT && npc_valid) pc_d = npc;
  end

  // PC, AR address, discard flag and the instruction handed to decode.
  // The AR address is kept apart from pc so a flush cannot move araddr while
  // arvalid is held; it is reloaded from pc only when a new fetch starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ar_addr_q  <= RESET_PC;
      discard_q  <= 1'b0;
      inst       <= '0;
      inst_pc    <= RESET_PC;
      inst_fault <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (state_d == S_AR && (state_q != S_AR || ar_misaligned))
        ar_addr_q <= pc_d;
      unique case (state_q)
        S_AR: begin
          if (!ar_misaligned && flush) discard_q <= 1'b1;
          if (ar_misaligned && !flush) begin
            inst       <= '0;
            inst_fault <= 1'b1;
            inst_pc    <= ar_addr_q;
          end
        end
        S_R: begin
          if (imem_rvalid) begin
            discard_q <= 1'b0;
            if (!discard_q && !flush) begin
              inst       <= imem_rdata;
              inst_fault <= (imem_rresp != 2'b00);
              inst_pc    <= ar_addr_q;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  // Fetch and bus-wait counters, free-running with natural wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_wait_cyc  <= '0;
    end else begin
      if (state_q == S_R && imem_rvalid)        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state_q == S_AR || state_q == S_R)    perf_wait_cyc  <= perf_wait_cyc + 32'd1;
    end
  end
`endif

endmodule
